// File: rtl/ibex_counter_csr_ctrl.sv
// CSR-side controller for a bank of ibex_counter instances: serialises read/write/set/clear
// requests, drives the counters' write strobes and shared write data, and gates increments.
module ibex_counter_csr_ctrl #(
  parameter int unsigned NumCounters = 2,
  parameter int unsigned IdxW        = (NumCounters > 1) ? $clog2(NumCounters) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      csr_req_i,
  output logic                      csr_gnt_o,
  input  logic [1:0]                csr_op_i,
  input  logic [IdxW:0]             csr_addr_i,
  input  logic [31:0]               csr_wdata_i,
  output logic                      csr_rvalid_o,
  output logic [31:0]               csr_rdata_o,
  output logic                      csr_err_o,
  input  logic [NumCounters-1:0]    event_i,
  input  logic [NumCounters-1:0]    inhibit_i,
  output logic [NumCounters-1:0]    cnt_inc_o,
  output logic [NumCounters-1:0]    cnt_we_o,
  output logic [NumCounters-1:0]    cnt_weh_o,
  output logic [31:0]               cnt_wdata_o,
  input  logic [64*NumCounters-1:0] cnt_val_i
);

  localparam int unsigned DataW   = 32;
  localparam int unsigned CntValW = 64;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [1:0]       op_q, op_d;
  logic [IdxW:0]    addr_q, addr_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic [DataW-1:0] old_q, old_d;
  logic             err_q, err_d;

  logic                   gnt_d;
  logic                   rvalid_d;
  logic [DataW-1:0]       rdata_d;
  logic                   err_out_d;
  logic [NumCounters-1:0] we_d, weh_d;
  logic [DataW-1:0]       cnt_wdata_d;

  logic [IdxW-1:0]        idx;
  logic [NumCounters-1:0] sel_oh;
  logic [CntValW-1:0]     sel_val;
  logic                   idx_ok;
  logic [DataW-1:0]       old_c;
  logic [DataW-1:0]       new_c;
  logic                   need_wr;

  // Increments go straight through; the write strobe takes priority inside the counter.
  assign cnt_inc_o = event_i & ~inhibit_i;

  assign idx = addr_q[IdxW:1];

  // One-hot counter select; an out-of-range index matches nothing and reads as zero.
  always_comb begin
    sel_oh  = '0;
    sel_val = '0;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      if (32'(idx) == i) begin
        sel_oh[i] = 1'b1;
        sel_val   = cnt_val_i[CntValW*i +: CntValW];
      end
    end
  end

  assign idx_ok = |sel_oh;
  assign old_c  = addr_q[0] ? sel_val[CntValW-1:DataW] : sel_val[DataW-1:0];

  always_comb begin
    new_c = old_c;
    case (op_q)
      OpWrite: new_c = wdata_q;
      OpSet:   new_c = old_c | wdata_q;
      OpClear: new_c = old_c & ~wdata_q;
      default: new_c = old_c;
    endcase
  end

  // Set/clear with an empty mask cannot change the counter, so it skips the write cycle.
  assign need_wr = idx_ok &&
                   ((op_q == OpWrite) ||
                    (((op_q == OpSet) || (op_q == OpClear)) && (wdata_q != '0)));

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    old_d       = old_q;
    err_d       = err_q;
    we_d        = '0;
    weh_d       = '0;
    cnt_wdata_d = cnt_wdata_o;
    gnt_d       = 1'b0;
    rvalid_d    = 1'b0;
    rdata_d     = '0;
    err_out_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (csr_req_i) begin
          op_d    = csr_op_i;
          addr_d  = csr_addr_i;
          wdata_d = csr_wdata_i;
          state_d = RD;
        end
      end
      RD: begin
        err_d = ~idx_ok;
        old_d = old_c;
        if (need_wr) begin
          we_d        = addr_q[0] ? '0 : sel_oh;
          weh_d       = addr_q[0] ? sel_oh : '0;
          cnt_wdata_d = new_c;
          state_d     = WR;
        end else begin
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    gnt_d = (state_d == IDLE);
    if (state_d == RESP) begin
      rvalid_d  = 1'b1;
      rdata_d   = old_d;
      err_out_d = err_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      op_q         <= OpRead;
      addr_q       <= '0;
      wdata_q      <= '0;
      old_q        <= '0;
      err_q        <= 1'b0;
      csr_gnt_o    <= 1'b1;
      csr_rvalid_o <= 1'b0;
      csr_rdata_o  <= '0;
      csr_err_o    <= 1'b0;
      cnt_we_o     <= '0;
      cnt_weh_o    <= '0;
      cnt_wdata_o  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      old_q        <= old_d;
      err_q        <= err_d;
      csr_gnt_o    <= gnt_d;
      csr_rvalid_o <= rvalid_d;
      csr_rdata_o  <= rdata_d;
      csr_err_o    <= err_out_d;
      cnt_we_o     <= we_d;
      cnt_weh_o    <= weh_d;
      cnt_wdata_o  <= cnt_wdata_d;
    end
  end

endmodule

// File: tb/tb_ibex_counter_csr_ctrl.sv
// Scoreboard bench for ibex_counter_csr_ctrl driving a behavioural bank of 10-bit counters.
module tb_ibex_counter_csr_ctrl;

  // Three counters so that index 3 exists in the address space and is out of range.
  localparam int unsigned N    = 3;
  localparam int unsigned IdxW = 2;
  localparam int unsigned CntW = 10;
  localparam int unsigned Mask = (1 << CntW) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 csr_req = 1'b0;
  logic                 csr_gnt;
  logic [1:0]           csr_op = 2'b00;
  logic [IdxW:0]        csr_addr = '0;
  logic [31:0]          csr_wdata = '0;
  logic                 csr_rvalid;
  logic [31:0]          csr_rdata;
  logic                 csr_err;
  logic [N-1:0]         event_v = '0;
  logic [N-1:0]         inhibit_v = '0;
  logic [N-1:0]         cnt_inc;
  logic [N-1:0]         cnt_we;
  logic [N-1:0]         cnt_weh;
  logic [31:0]          cnt_wdata;
  logic [64*N-1:0]      cnt_val;

  always #5 clk = ~clk;

  ibex_counter_csr_ctrl #(.NumCounters(N), .IdxW(IdxW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .csr_req_i(csr_req), .csr_gnt_o(csr_gnt), .csr_op_i(csr_op),
    .csr_addr_i(csr_addr), .csr_wdata_i(csr_wdata),
    .csr_rvalid_o(csr_rvalid), .csr_rdata_o(csr_rdata), .csr_err_o(csr_err),
    .event_i(event_v), .inhibit_i(inhibit_v), .cnt_inc_o(cnt_inc),
    .cnt_we_o(cnt_we), .cnt_weh_o(cnt_weh), .cnt_wdata_o(cnt_wdata),
    .cnt_val_i(cnt_val)
  );

  // Counter bank: 10-bit counters, write beats increment, high-half writes have no storage.
  logic [CntW-1:0] cnt [N] = '{default: '0};
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (cnt_we[i])       cnt[i] <= cnt_wdata[CntW-1:0];
      else if (cnt_inc[i]) cnt[i] <= cnt[i] + 1'b1;
    end
  end
  always_comb begin
    for (int i = 0; i < N; i++) cnt_val[64*i +: 64] = 64'(cnt[i]);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { int cyc; logic [N-1:0] we; logic [N-1:0] weh; logic [31:0] wdata; } stb_t;

  rsp_t rsp_q[$];
  stb_t stb_q[$];
  int unsigned ref_cnt [N];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or a write strobe.
  rsp_t mr;
  stb_t ms;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cnt_inc", 64'(cnt_inc), 64'(event_v & ~inhibit_v));
      if (csr_rvalid) begin
        if (rsp_q.size() == 0) chk("unexpected_rvalid", 64'(1), 64'(0));
        else begin
          mr = rsp_q.pop_front();
          chk("rvalid_cycle", 64'(cyc), 64'(mr.cyc));
          chk("rdata", 64'(csr_rdata), 64'(mr.rdata));
          chk("err", 64'(csr_err), 64'(mr.err));
        end
      end
      if ((cnt_we != '0) || (cnt_weh != '0)) begin
        if (stb_q.size() == 0) chk("unexpected_strobe", 64'({cnt_weh, cnt_we}), 64'(0));
        else begin
          ms = stb_q.pop_front();
          chk("strobe_cycle", 64'(cyc), 64'(ms.cyc));
          chk("cnt_we", 64'(cnt_we), 64'(ms.we));
          chk("cnt_weh", 64'(cnt_weh), 64'(ms.weh));
          chk("cnt_wdata", 64'(cnt_wdata), 64'(ms.wdata));
        end
      end
    end
  end

  // Issue one request; when tracked, predict its response and strobe from the reference counts.
  task automatic issue(input logic [1:0] op, input logic [IdxW:0] addr, input logic [31:0] wd,
                       input bit track);
    int a;
    int guard;
    int unsigned idx;
    logic [63:0] full;
    logic [31:0] old_v, new_v;
    logic [N-1:0] oh;
    rsp_t r;
    stb_t s;
    guard = 0;
    @(negedge clk);
    while (!csr_gnt && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!csr_gnt) chk("gnt_timeout", 64'(csr_gnt), 64'(1));
    csr_req = 1'b1; csr_op = op; csr_addr = addr; csr_wdata = wd;
    @(posedge clk); #1;
    a = cyc;
    csr_req = 1'b0;
    if (track) begin
      idx = int'(addr[IdxW:1]);
      if (idx >= N) begin
        r.cyc = a + 1; r.rdata = '0; r.err = 1'b1;
      end else begin
        full  = 64'(ref_cnt[idx]);
        old_v = addr[0] ? full[63:32] : full[31:0];
        case (op)
          2'b01:   new_v = wd;
          2'b10:   new_v = old_v | wd;
          2'b11:   new_v = old_v & ~wd;
          default: new_v = old_v;
        endcase
        r.rdata = old_v; r.err = 1'b0;
        if (op == 2'b01 || (op != 2'b00 && wd != 0)) begin
          oh = '0; oh[idx] = 1'b1;
          s.cyc = a + 1; s.we = addr[0] ? '0 : oh; s.weh = addr[0] ? oh : '0; s.wdata = new_v;
          stb_q.push_back(s);
          r.cyc = a + 2;
          if (!addr[0]) ref_cnt[idx] = new_v & Mask;
        end else begin
          r.cyc = a + 1;
        end
      end
      rsp_q.push_back(r);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((rsp_q.size() != 0 || stb_q.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk("drain", 64'(rsp_q.size() + stb_q.size()), 64'(0));
  endtask

  task automatic check_bank();
    for (int i = 0; i < N; i++) chk($sformatf("bank%0d", i), 64'(cnt[i]), 64'(ref_cnt[i]));
  endtask

  task automatic inc_phase(input int cycles, input bit rnd, input logic [N-1:0] ev,
                           input logic [N-1:0] inh);
    for (int k = 0; k < cycles; k++) begin
      if (rnd) begin
        ev  = N'($urandom);
        inh = N'($urandom);
      end
      event_v = ev; inhibit_v = inh;
      for (int i = 0; i < N; i++) if (ev[i] && !inh[i]) ref_cnt[i] = (ref_cnt[i] + 1) & Mask;
      @(posedge clk); #1;
    end
    event_v = '0; inhibit_v = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) ref_cnt[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(csr_gnt), 64'(1));
    chk("rst_rvalid", 64'(csr_rvalid), 64'(0));
    chk("rst_err", 64'(csr_err), 64'(0));
    chk("rst_rdata", 64'(csr_rdata), 64'(0));
    chk("rst_we", 64'({cnt_weh, cnt_we}), 64'(0));
    chk("rst_wdata", 64'(cnt_wdata), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("gnt_after_rst", 64'(csr_gnt), 64'(1));

    // Write idx1 low half, then read it back.
    issue(2'b01, 3'b010, 32'h155, 1);
    issue(2'b00, 3'b010, 32'h0, 1);
    drain();
    chk("cnt1_written", 64'(cnt[1]), 64'(10'h155));

    // Set then clear on counter 0.
    issue(2'b01, 3'b000, 32'h0F0, 1);
    issue(2'b10, 3'b000, 32'h00F, 1);
    drain();
    chk("cnt0_after_set", 64'(cnt[0]), 64'(10'h0FF));
    issue(2'b11, 3'b000, 32'h0F0, 1);
    drain();
    chk("cnt0_after_clear", 64'(cnt[0]), 64'(10'h00F));

    // Out-of-range index, empty-mask set, high-half read and high-half write.
    issue(2'b01, 3'b110, 32'hFFFF_FFFF, 1);
    issue(2'b10, 3'b000, 32'h0, 1);
    issue(2'b00, 3'b001, 32'h0, 1);
    issue(2'b01, 3'b011, 32'hABCD_0000, 1);
    drain();
    check_bank();

    // Inhibited counter 0, counter 1 counts five events.
    inc_phase(5, 1'b0, 3'b011, 3'b001);
    @(negedge clk);
    chk("cnt1_plus5", 64'(cnt[1]), 64'(10'h15A));
    chk("cnt0_inhibited", 64'(cnt[0]), 64'(10'h00F));
    check_bank();

    // Increments during RD and WR on the written counter are overwritten.
    issue(2'b01, 3'b000, 32'h2A5, 1);
    event_v = 3'b001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    event_v = '0;
    drain();
    chk("race_write_wins", 64'(cnt[0]), 64'(10'h2A5));

    // Reset during the write cycle aborts the request silently.
    issue(2'b01, 3'b100, 32'h3C3, 0);
    @(posedge clk); #1;
    chk("strobe_before_rst", 64'(cnt_we), 64'(3'b100));
    rst_n = 1'b0;
    #1;
    chk("we_drop_in_rst", 64'({cnt_weh, cnt_we}), 64'(0));
    chk("gnt_in_rst", 64'(csr_gnt), 64'(1));
    repeat (2) begin
      @(negedge clk);
      chk("rvalid_in_rst", 64'(csr_rvalid), 64'(0));
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_rvalid_after_abort", 64'(csr_rvalid), 64'(0));
    end
    chk("gnt_after_abort", 64'(csr_gnt), 64'(1));
    check_bank();

    // Randomised traffic interleaved with random increment bursts.
    for (int n = 0; n < 60; n++) begin
      issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom, 1);
      if (n % 10 == 9) begin
        drain();
        inc_phase(8, 1'b1, '0, '0);
        @(negedge clk);
        check_bank();
      end
    end
    drain();
    check_bank();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
